// File: rtl/karatsuba_mult_scheduler.sv
// Two-requester round-robin issue scheduler for a shared Karatsuba multiplier with an in-order result FIFO.
// Define KPM_SCHED_PERF_EN to add saturating issue/stall performance counters.
module karatsuba_mult_scheduler #(
    parameter int N = 4,
    parameter int D = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic                   req1_valid,
    output logic                   req0_ready,
    output logic                   req1_ready,
    input  logic [D*N-1:0]         req0_a,
    input  logic [D*N-1:0]         req0_b,
    input  logic [D*N-1:0]         req1_a,
    input  logic [D*N-1:0]         req1_b,
    output logic [D*N-1:0]         mul_a,
    output logic [D*N-1:0]         mul_b,
    input  logic [(2*D-1)*N-1:0]   mul_p,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [(2*D-1)*N-1:0]   rsp_p
`ifdef KPM_SCHED_PERF_EN
    ,
    output logic [15:0]            perf_issue_cnt,
    output logic [15:0]            perf_stall_cnt
`endif
);

    localparam int LAT   = $clog2(D) - 1;
    localparam int DEPTH = LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PW    = (2*D-1)*N;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    typedef struct packed {
        logic          id;
        logic [PW-1:0] p;
    } entry_t;

    tag_t             tags [LAT];
    entry_t           mem  [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] credits_used;   // issued but not yet popped: pipeline plus FIFO
    logic             prio;
    logic             issue, grant_id, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Readys are also held low while rst is asserted, since this path is purely combinational.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        issue      = 1'b0;
        grant_id   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        if (rst && credits_used < CNT_W'(DEPTH)) begin
            if (req0_valid && !(req1_valid && prio)) begin
                issue      = 1'b1;
                req0_ready = 1'b1;
                mul_a      = req0_a;
                mul_b      = req0_b;
            end else if (req1_valid) begin
                issue      = 1'b1;
                grant_id   = 1'b1;
                req1_ready = 1'b1;
                mul_a      = req1_a;
                mul_b      = req1_b;
            end
        end
    end

    assign push      = tags[LAT-1].valid;
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_id    = rsp_valid ? mem[rd_ptr].id : 1'b0;
    assign rsp_p     = rsp_valid ? mem[rd_ptr].p  : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) tags[i] <= '0;
        end else begin
            tags[0] <= '{valid: issue, id: grant_id};
            for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            credits_used <= '0;
            prio         <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            case ({issue, pop})
                2'b10:   credits_used <= credits_used + 1'b1;
                2'b01:   credits_used <= credits_used - 1'b1;
                default: credits_used <= credits_used;
            endcase
            if (issue) prio <= ~prio;
        end
    end

    // NOTE: payload storage is not reset; the outputs are gated by rsp_valid instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{id: tags[LAT-1].id, p: mul_p};
    end

`ifdef KPM_SCHED_PERF_EN
    logic stall;
    assign stall = (req0_valid || req1_valid) && !issue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue && perf_issue_cnt != 16'hFFFF) perf_issue_cnt <= perf_issue_cnt + 1'b1;
            if (stall && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_karatsuba_mult_scheduler.sv
// Randomized self-checking bench for karatsuba_mult_scheduler against a transaction-level scoreboard model.
// The bench also plays the shared multiplier (one-cycle polynomial product, coefficients mod 2^N).
module tb_karatsuba_mult_scheduler;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 3;
    localparam int W     = D*N;
    localparam int PW    = (2*D-1)*N;

    logic          clk, rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b, mul_a, mul_b;
    logic [PW-1:0] mul_p, rsp_p;
    logic          rsp_valid, rsp_ready, rsp_id;
`ifdef KPM_SCHED_PERF_EN
    logic [15:0]   perf_issue_cnt, perf_stall_cnt;
`endif

    karatsuba_mult_scheduler #(.N(N), .D(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_p      (rsp_p)
`ifdef KPM_SCHED_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] poly_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PW-1:0] r;
        int            c;
        r = '0;
        for (int k = 0; k < 2*D-1; k++) begin
            c = 0;
            for (int i = 0; i < D; i++) begin
                if (k - i >= 0 && k - i < D)
                    c += int'(a[i*N +: N]) * int'(b[(k-i)*N +: N]);
            end
            r[k*N +: N] = N'(c);
        end
        return r;
    endfunction

    // Shared multiplier stand-in with LAT = 1.
    always @(posedge clk) mul_p <= poly_mul(mul_a, mul_b);

    typedef struct {
        bit            id;
        logic [PW-1:0] p;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    int   occ;
    bit   prio;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock: check outputs on the falling edge against the model, advance the model, return just after the rising edge.
    task automatic tick();
        bit           g0, g1, ev;
        logic [W-1:0] ea, eb;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            exp_q.delete();
            occ  = 0;
            prio = 1'b0;
            check("rst_req0_ready", req0_ready, 0);
            check("rst_req1_ready", req1_ready, 0);
            check("rst_rsp_valid",  rsp_valid,  0);
            check("rst_rsp_id",     rsp_id,     0);
            check("rst_rsp_p",      rsp_p,      0);
            check("rst_mul_a",      mul_a,      0);
            check("rst_mul_b",      mul_b,      0);
        end else begin
            g0 = 1'b0;
            g1 = 1'b0;
            if (occ < DEPTH) begin
                if (req0_valid && (!req1_valid || prio == 1'b0)) g0 = 1'b1;
                else if (req1_valid)                             g1 = 1'b1;
            end
            ea = g0 ? req0_a : (g1 ? req1_a : '0);
            eb = g0 ? req0_b : (g1 ? req1_b : '0);
            check("req0_ready", req0_ready, g0);
            check("req1_ready", req1_ready, g1);
            check("mul_a", mul_a, ea);
            check("mul_b", mul_b, eb);
            ev = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            check("rsp_valid", rsp_valid, ev);
            if (ev) begin
                check("rsp_id", rsp_id, exp_q[0].id);
                check("rsp_p",  rsp_p,  exp_q[0].p);
            end
            if (ev && rsp_ready) begin
                void'(exp_q.pop_front());
                occ--;
            end
            if (g0 || g1) begin
                exp_q.push_back('{g1, poly_mul(ea, eb), cyc + LAT + 1});
                occ++;
                prio = ~prio;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic rand_ops();
        req0_a = W'($urandom);
        req0_b = W'($urandom);
        req1_a = W'($urandom);
        req1_b = W'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int k;
        int issues;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        occ   = 0;
        prio  = 1'b0;
        rst   = 1'b0;
        rsp_ready = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rand_ops();
        @(posedge clk);
        #1;
        do_reset();

        // Single operation right after reset release.
        req0_valid = 1'b1;
        req0_a     = 16'h0001;
        req0_b     = 16'h0003;
        rsp_ready  = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        check("single_rsp_valid", rsp_valid, 1);
        check("single_rsp_id",    rsp_id,    0);
        check("single_rsp_p",     rsp_p,     28'h0000003);
        repeat (3) tick();

        // Both requesters valid: grants and results alternate.
        do_reset();
        rsp_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            req0_valid = (i < 6);
            req1_valid = (i < 6);
            rand_ops();
            #1;
            if (i < 6) check("rr_grant_req1", req1_ready, i % 2);
            if (rsp_valid) begin
                check("rr_rsp_id", rsp_id, k % 2);
                k++;
            end
            tick();
        end
        check("rr_rsp_count", k, 6);

        // Backpressure: credits cap issues at DEPTH, then drain in order.
        do_reset();
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        issues = 0;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            #1;
            if (req0_ready) issues++;
            tick();
        end
        check("bp_issues", issues, DEPTH);
        check("bp_ready_low", req0_ready, 0);
        check("bp_fifo_full_valid", rsp_valid, 1);
        req0_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (6) tick();

        // Random traffic with intermittent backpressure.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            rsp_ready  = ($urandom_range(0, 2) != 0);
            rand_ops();
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (8) tick();

        // Reset with two operations outstanding discards them.
        do_reset();
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rand_ops();
        tick();
        rand_ops();
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_p",     rsp_p,     0);
        tick();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        repeat (6) tick();

`ifdef KPM_SCHED_PERF_EN
        // Five issues and three blocked cycles.
        do_reset();
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        repeat (6) tick();
        req0_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (3) tick();
        req0_valid = 1'b1;
        repeat (2) tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        check("perf_issue_cnt", perf_issue_cnt, 5);
        check("perf_stall_cnt", perf_stall_cnt, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/karatsuba_mult_scheduler.md
KARATSUBA_MULT_SCHEDULER -- requirements
Module: karatsuba_mult_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 4: coefficient width in bits.
REQ-002 The block SHALL have parameter D, default 4: coefficients per operand, a power of two with D>=4.
REQ-003 The block SHALL have derived localparam LAT = clog2(D)-1: multiplier latency in cycles (D=4 gives 1; D=8 gives 2).
REQ-004 The block SHALL have derived localparam DEPTH = LAT+2: result FIFO entries.
REQ-005 Port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Ports req0_valid and req1_valid, input, 1 bit each: requester has an operand pair.
REQ-008 Ports req0_ready and req1_ready, output, 1 bit each: pair accepted this cycle.
REQ-009 Ports req0_a, req0_b, req1_a and req1_b, input, D*N bits each: operand polynomials.
REQ-010 Ports mul_a and mul_b, output, D*N bits each: operands to the shared Karatsuba multiplier.
REQ-011 Port mul_p, input, (2D-1)*N bits: multiplier product, valid LAT cycles after issue.
REQ-012 Port rsp_valid, output, 1 bit; port rsp_ready, input, 1 bit: result handshake.
REQ-013 Port rsp_id, output, 1 bit: requester index of the result; port rsp_p, output, (2D-1)*N bits: product.

Function
REQ-014 The block SHALL issue at most one operation per cycle, when a requester's valid is high and the grant condition holds; the issue cycle is the cycle in which that requester's ready is high.
REQ-015 The grant condition SHALL be inflight + fifo_count < DEPTH, counted before this cycle's updates; this guarantees no product is ever dropped.
REQ-016 Arbitration SHALL be round-robin: the priority pointer moves to the other requester after each grant; with one requester valid, that requester wins regardless of the pointer.
REQ-017 req0_ready and req1_ready SHALL be combinational, mutually exclusive, and never high without the matching valid.
REQ-018 mul_a and mul_b SHALL carry the granted operands combinationally in the issue cycle, and SHALL be all-zero when nothing issues.
REQ-019 A LAT-stage tag pipeline of {valid, id} SHALL advance every cycle; when its tail is valid, mul_p and the id SHALL be written into the FIFO in that cycle.
REQ-020 rsp_valid SHALL equal FIFO not-empty; rsp_id and rsp_p SHALL show the FIFO head; an entry pops on rsp_valid && rsp_ready.
REQ-021 When push and pop occur in the same cycle, the FIFO count SHALL be unchanged and both SHALL take effect; pointers wrap modulo DEPTH.
REQ-022 Results SHALL leave in issue order; a pop SHALL free one credit for issue in the next cycle, not the same cycle.
REQ-023 Sustained throughput SHALL be one operation per cycle while rsp_ready is held high.

Reset
REQ-024 While rst is low: tag pipeline invalid, FIFO empty, pointers 0, priority pointer on req0, rsp_valid=0, rsp_id=0, rsp_p=0, mul_a=mul_b=0, both readys 0.
REQ-025 Asserting reset mid-operation SHALL discard all in-flight and buffered results; after release the block SHALL accept requests in the first clock edge.

Configuration
REQ-026 With macro KPM_SCHED_PERF_EN defined, outputs perf_issue_cnt[15:0] and perf_stall_cnt[15:0] SHALL exist; they count issues and cycles with any valid high but no issue, saturate at 16'hFFFF and reset to 0.
REQ-027 Without KPM_SCHED_PERF_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (N=4, D=4, LAT=1, DEPTH=3)
REQ-028 Single op: req0 a=16'h0001, b=16'h0003, rsp_ready=1 -> rsp_valid 2 cycles after issue, rsp_id=0, rsp_p=28'h0000003.
REQ-029 Both valid every cycle for 6 cycles, rsp_ready=1 -> grants alternate 0,1,0,1,0,1; rsp_id sequence matches.
REQ-030 rsp_ready=0 with req0 continuously valid -> exactly 3 issues, then req0_ready stays 0 and the FIFO holds 3 results; raising rsp_ready drains them in order.
REQ-031 FIFO full with push and pop in the same cycle under steady backpressure release -> no loss or duplication over 20 random ops, checked against a reference model.
REQ-032 Reset asserted with 2 ops in flight -> rsp_valid=0 immediately; no stale result after release.
REQ-033 With KPM_SCHED_PERF_EN: 5 issues plus 3 blocked cycles -> perf_issue_cnt=5, perf_stall_cnt=3.
